// File: rtl/mult_share_arbiter_pkg.sv
// Shared types and defaults for the multiplier-sharing arbiter.
package mult_share_pkg;

  localparam int unsigned NUM_REQ_DEF     = 4;
  localparam int unsigned DATA_LEN_DEF    = 32;
  localparam int unsigned MUL_LATENCY_DEF = 2;
  localparam int unsigned NUM_REQ_MAX     = 8;
  // Tag ids are sized for the largest supported requester count
  localparam int unsigned TAG_ID_W        = $clog2(NUM_REQ_MAX);

  typedef enum logic [2:0] {
    S_MRST,
    S_RUN,
    S_DRAIN,
    S_FRST,
    S_DONE
  } t_arb_state;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } t_tag;

endpackage

// File: rtl/mult_share_arbiter_if.sv
// Per-requester request/response channels between requesters and the arbiter.
interface mult_share_arbiter_if
  import mult_share_pkg::*;
#(
  parameter int unsigned NUM_REQ  = NUM_REQ_DEF,
  parameter int unsigned DATA_LEN = DATA_LEN_DEF
) ();

  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ-1:0]          req_ready;
  logic [NUM_REQ*DATA_LEN-1:0] req_a;
  logic [NUM_REQ*DATA_LEN-1:0] req_b;
  logic [NUM_REQ-1:0]          rsp_valid;
  logic [NUM_REQ-1:0]          rsp_ready;
  logic [NUM_REQ*DATA_LEN-1:0] rsp_result;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result
  );

endinterface

// File: rtl/mult_share_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first eligible
// requester at or after rr_ptr, wrapping.
module rr_arbiter
  import mult_share_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF
) (
  input  logic [NUM_REQ-1:0]         eligible,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  output logic [NUM_REQ-1:0]         grant
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  logic             found;
  logic [PTR_W-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = PTR_W'((32'(rr_ptr) + k) % NUM_REQ);
      if (!found && eligible[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one fixed-latency pipelined multiplier among NUM_REQ requesters,
// routing results back by tag and offering a drain-and-reset flush.
module mult_share_arbiter
  import mult_share_pkg::*;
#(
  parameter int unsigned NUM_REQ     = NUM_REQ_DEF,
  parameter int unsigned DATA_LEN    = DATA_LEN_DEF,
  parameter int unsigned MUL_LATENCY = MUL_LATENCY_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  mult_share_arbiter_if.slave bus,
  input  logic                flush_req,
  output logic                flush_done,
  output logic                idle,
  output logic                mul_reset,
  output logic [DATA_LEN-1:0] mul_a,
  output logic [DATA_LEN-1:0] mul_b,
  input  logic [DATA_LEN-1:0] mul_result
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  t_arb_state                  state, state_next;
  logic                        run;
  logic [PTR_W-1:0]            rr_ptr;
  logic [NUM_REQ-1:0]          busy, eligible, grant, req_ready;
  logic [NUM_REQ-1:0]          rsp_valid, rsp_hs, capture;
  logic [NUM_REQ*DATA_LEN-1:0] rsp_result;
  logic [PTR_W-1:0]            gid;
  logic [DATA_LEN-1:0]         grant_a, grant_b;
  logic                        granted, pipe_empty;
  t_tag                        issue_tag;
  t_tag                        tag_pipe [MUL_LATENCY];
  t_tag                        tag_out;

  assign eligible = bus.req_valid & ~busy;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .eligible (eligible),
    .rr_ptr   (rr_ptr),
    .grant    (grant)
  );

  // Next-state logic; grants are only allowed in S_RUN
  always_comb begin
    state_next = state;
    run        = 1'b0;
    unique case (state)
      S_MRST:  state_next = S_RUN;
      S_RUN: begin
        run = 1'b1;
        if (flush_req) state_next = S_DRAIN;
      end
      S_DRAIN: if (pipe_empty) state_next = S_FRST;
      S_FRST:  state_next = S_DONE;
      S_DONE:  state_next = S_RUN;
      default: state_next = S_MRST;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_MRST;
      mul_reset  <= 1'b1;
      flush_done <= 1'b0;
    end else begin
      state      <= state_next;
      mul_reset  <= (state_next == S_MRST) || (state_next == S_FRST);
      flush_done <= (state_next == S_DONE);
    end
  end

  assign req_ready = grant & {NUM_REQ{run}};
  assign granted   = |req_ready;

  always_comb begin
    gid     = '0;
    grant_a = '0;
    grant_b = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        gid     = PTR_W'(i);
        grant_a = bus.req_a[i*DATA_LEN +: DATA_LEN];
        grant_b = bus.req_b[i*DATA_LEN +: DATA_LEN];
      end
    end
  end

  // The issue stage plus MUL_LATENCY tag stages line the tag up with mul_result
  assign tag_out = tag_pipe[MUL_LATENCY-1];

  always_comb begin
    pipe_empty = ~issue_tag.valid;
    for (int unsigned k = 0; k < MUL_LATENCY; k++) begin
      pipe_empty = pipe_empty & ~tag_pipe[k].valid;
    end
  end

  always_comb begin
    capture = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      capture[i] = tag_out.valid && (tag_out.id == TAG_ID_W'(i));
    end
  end

  assign rsp_hs = rsp_valid & bus.rsp_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mul_a      <= '0;
      mul_b      <= '0;
      issue_tag  <= '0;
      for (int unsigned k = 0; k < MUL_LATENCY; k++) tag_pipe[k] <= '0;
      rr_ptr     <= '0;
      busy       <= '0;
      rsp_valid  <= '0;
      rsp_result <= '0;
    end else begin
      mul_a       <= grant_a;
      mul_b       <= grant_b;
      issue_tag   <= '{valid: granted, id: TAG_ID_W'(gid)};
      tag_pipe[0] <= issue_tag;
      for (int unsigned k = 1; k < MUL_LATENCY; k++) tag_pipe[k] <= tag_pipe[k-1];
      if (granted) begin
        rr_ptr <= (gid == PTR_W'(NUM_REQ - 1)) ? '0 : gid + PTR_W'(1);
      end
      // busy guarantees a capture never lands on a pending response
      busy      <= (busy | req_ready) & ~rsp_hs;
      rsp_valid <= (rsp_valid & ~rsp_hs) | capture;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (capture[i]) rsp_result[i*DATA_LEN +: DATA_LEN] <= mul_result;
      end
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.rsp_valid  = rsp_valid;
  assign bus.rsp_result = rsp_result;
  assign idle           = pipe_empty & ~|rsp_valid & run;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Self-checking bench for mult_share_arbiter with a pipelined multiplier model.
module tb_mult_share_arbiter;
  import mult_share_pkg::*;

  localparam int unsigned NUM_REQ     = NUM_REQ_DEF;
  localparam int unsigned DATA_LEN    = DATA_LEN_DEF;
  localparam int unsigned MUL_LATENCY = MUL_LATENCY_DEF;
  localparam int unsigned RSP_LAT     = MUL_LATENCY + 2;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                flush_req;
  logic                flush_done;
  logic                idle;
  logic                mul_reset;
  logic [DATA_LEN-1:0] mul_a, mul_b, mul_result;

  int checks = 0;
  int errors = 0;

  mult_share_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_LEN(DATA_LEN)) bus ();

  mult_share_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_LEN(DATA_LEN), .MUL_LATENCY(MUL_LATENCY)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .flush_req  (flush_req),
    .flush_done (flush_done),
    .idle       (idle),
    .mul_reset  (mul_reset),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_result (mul_result)
  );

  always #5 clk = ~clk;

  // Pipelined multiplier with synchronous active-high reset
  logic [DATA_LEN-1:0] mpipe [MUL_LATENCY];
  always @(posedge clk) begin
    if (mul_reset) begin
      for (int k = 0; k < int'(MUL_LATENCY); k++) mpipe[k] <= '0;
    end else begin
      mpipe[0] <= mul_a * mul_b;
      for (int k = 1; k < int'(MUL_LATENCY); k++) mpipe[k] <= mpipe[k-1];
    end
  end
  assign mul_result = mpipe[MUL_LATENCY-1];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [DATA_LEN-1:0] rslice(input int unsigned i);
    return bus.rsp_result[i*DATA_LEN +: DATA_LEN];
  endfunction

  task automatic set_op(input int unsigned i, input logic [DATA_LEN-1:0] a,
                        input logic [DATA_LEN-1:0] b);
    bus.req_a[i*DATA_LEN +: DATA_LEN] = a;
    bus.req_b[i*DATA_LEN +: DATA_LEN] = b;
  endtask

  task automatic wait_idle(input string name);
    bus.rsp_ready = '1;
    bus.req_valid = '0;
    for (int n = 0; n < 30 && !idle; n++) tick();
    settle();
    chk(name, 64'(idle), 64'd1);
  endtask

  typedef struct {
    logic [DATA_LEN-1:0] a;
    logic [DATA_LEN-1:0] b;
    int unsigned         id;
    logic [DATA_LEN-1:0] exp;
  } vec_t;

  vec_t vecs [6];
  logic [NUM_REQ-1:0] exp_rr [9];

  // Random-phase reference state
  logic [NUM_REQ-1:0]  pend, m_busy, exp_g, exp_rv;
  logic [DATA_LEN-1:0] pa [NUM_REQ];
  logic [DATA_LEN-1:0] pb [NUM_REQ];
  logic [DATA_LEN-1:0] m_exp [NUM_REQ];
  int                  m_due [NUM_REQ];
  int unsigned         m_ptr, j;

  initial begin
    vecs[0] = '{32'd7,          32'd6,          0, 32'd42};
    vecs[1] = '{32'h0000_FFFF,  32'h0001_0001,  1, 32'hFFFF_FFFF};
    vecs[2] = '{32'd0,          32'hDEAD_BEEF,  2, 32'd0};
    vecs[3] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  3, 32'd1};
    vecs[4] = '{32'h0001_0000,  32'h0001_0000,  0, 32'd0};
    vecs[5] = '{32'h1234_5678,  32'd1,          2, 32'h1234_5678};
    exp_rr  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000,
                4'b0001, 4'b0010, 4'b0100, 4'b1000};

    // Reset values, with requests pending
    reset_n = 1'b0;
    flush_req = 1'b0;
    bus.req_valid = '1;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.rsp_ready = '0;
    repeat (2) tick();
    settle();
    chk("rst_mul_reset", 64'(mul_reset), 64'd1);
    chk("rst_mul_a", 64'(mul_a), 64'd0);
    chk("rst_mul_b", 64'(mul_b), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_result", 64'(bus.rsp_result[63:0]), 64'd0);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_flush_done", 64'(flush_done), 64'd0);
    chk("rst_idle", 64'(idle), 64'd0);
    reset_n = 1'b1;
    settle();
    chk("mrst_mul_reset", 64'(mul_reset), 64'd1);
    chk("mrst_no_grant", 64'(bus.req_ready), 64'd0);
    bus.req_valid = '0;
    tick();
    settle();
    chk("run_mul_reset", 64'(mul_reset), 64'd0);
    chk("run_idle", 64'(idle), 64'd1);

    // All four requesters from rr_ptr=0, re-granted after each response
    for (int i = 0; i < int'(NUM_REQ); i++) set_op(i, DATA_LEN'(i + 2), DATA_LEN'(i + 3));
    bus.rsp_ready = '1;
    bus.req_valid = '1;
    for (int c = 0; c < 9; c++) begin
      settle();
      chk("rr_all_grant", 64'(bus.req_ready), 64'(exp_rr[c]));
      if (c >= 4 && c < 8) begin
        chk("rr_all_rsp_valid", 64'(bus.rsp_valid[c-4]), 64'd1);
        chk("rr_all_result", 64'(rslice(c - 4)), 64'((c - 2) * (c - 1)));
      end
      tick();
    end
    wait_idle("rr_all_idle");

    // Table-driven single operations: grant, operand issue, exact latency
    for (int v = 0; v < 6; v++) begin
      set_op(vecs[v].id, vecs[v].a, vecs[v].b);
      bus.rsp_ready = '0;
      bus.req_valid = NUM_REQ'(1) << vecs[v].id;
      settle();
      chk("vec_grant", 64'(bus.req_ready), 64'(NUM_REQ'(1) << vecs[v].id));
      tick();
      bus.req_valid = '0;
      settle();
      chk("vec_mul_a", 64'(mul_a), 64'(vecs[v].a));
      chk("vec_mul_b", 64'(mul_b), 64'(vecs[v].b));
      repeat (RSP_LAT - 2) tick();
      settle();
      chk("vec_rsp_early", 64'(bus.rsp_valid), 64'd0);
      tick();
      settle();
      chk("vec_rsp_valid", 64'(bus.rsp_valid), 64'(NUM_REQ'(1) << vecs[v].id));
      chk("vec_result", 64'(rslice(vecs[v].id)), 64'(vecs[v].exp));
      bus.rsp_ready = NUM_REQ'(1) << vecs[v].id;
      tick();
      bus.rsp_ready = '0;
      settle();
      chk("vec_rsp_cleared", 64'(bus.rsp_valid), 64'd0);
      chk("vec_result_held", 64'(rslice(vecs[v].id)), 64'(vecs[v].exp));
      chk("vec_idle", 64'(idle), 64'd1);
    end

    // Wrap: last grant was requester 2, so rr_ptr=3
    set_op(3, 32'd2, 32'd5);
    set_op(0, 32'd3, 32'd7);
    bus.rsp_ready = '1;
    bus.req_valid = 4'b1001;
    settle();
    chk("wrap_grant3", 64'(bus.req_ready), 64'b1000);
    tick();
    settle();
    chk("wrap_grant0", 64'(bus.req_ready), 64'b0001);
    tick();
    wait_idle("wrap_idle");

    // Backpressure on requester 1 while requester 2 keeps being served
    set_op(1, 32'h0000_FFFF, 32'h0001_0001);
    set_op(2, 32'd5, 32'd9);
    bus.rsp_ready = 4'b1101;
    bus.req_valid = 4'b0010;
    settle();
    chk("bp_grant1", 64'(bus.req_ready), 64'b0010);
    repeat (RSP_LAT) tick();
    for (int k = 0; k < 10; k++) begin
      bus.req_valid = (k == 0) ? 4'b0110 : 4'b0010;
      settle();
      chk("bp_hold_valid", 64'(bus.rsp_valid[1]), 64'd1);
      chk("bp_hold_result", 64'(rslice(1)), 64'hFFFF_FFFF);
      chk("bp_grant", 64'(bus.req_ready), (k == 0) ? 64'b0100 : 64'b0000);
      if (k == 4) begin
        chk("bp_req2_rsp", 64'(bus.rsp_valid[2]), 64'd1);
        chk("bp_req2_result", 64'(rslice(2)), 64'd45);
      end
      tick();
    end
    bus.rsp_ready = '1;
    settle();
    chk("bp_no_regrant", 64'(bus.req_ready), 64'd0);
    tick();
    settle();
    chk("bp_regrant", 64'(bus.req_ready), 64'b0010);
    chk("bp_result_held", 64'(rslice(1)), 64'hFFFF_FFFF);
    tick();
    wait_idle("bp_idle");

    // Flush with two ops in flight (rr_ptr=2 here)
    set_op(1, 32'd11, 32'd13);
    set_op(2, 32'd100, 32'd200);
    set_op(0, 32'd9, 32'd9);
    bus.rsp_ready = '1;
    bus.req_valid = 4'b0110;
    settle();
    chk("flush_first_grant", 64'(bus.req_ready), 64'b0100);
    tick();
    bus.req_valid = 4'b0010;
    flush_req = 1'b1;
    settle();
    chk("flush_cycle_grant", 64'(bus.req_ready), 64'b0010);
    tick();
    flush_req = 1'b0;
    bus.req_valid = 4'b0001;
    for (int c = 2; c < 8; c++) begin
      settle();
      chk("drain_no_grant", 64'(bus.req_ready), 64'd0);
      chk("flush_mul_reset", 64'(mul_reset), (c == 6) ? 64'd1 : 64'd0);
      chk("flush_done", 64'(flush_done), (c == 7) ? 64'd1 : 64'd0);
      chk("flush_not_idle", 64'(idle), 64'd0);
      if (c == 4) begin
        chk("flush_rsp2", 64'(bus.rsp_valid[2]), 64'd1);
        chk("flush_result2", 64'(rslice(2)), 64'd20000);
      end
      if (c == 5) begin
        chk("flush_rsp1", 64'(bus.rsp_valid[1]), 64'd1);
        chk("flush_result1", 64'(rslice(1)), 64'd143);
      end
      tick();
    end
    settle();
    chk("flush_resume_grant", 64'(bus.req_ready), 64'b0001);
    chk("flush_done_pulse", 64'(flush_done), 64'd0);
    tick();
    wait_idle("flush_idle");
    chk("flush_after_result0", 64'(rslice(0)), 64'd81);

    // Reset with an op in flight
    set_op(3, 32'd3, 32'd4);
    bus.rsp_ready = '0;
    bus.req_valid = 4'b1000;
    settle();
    chk("mid_grant", 64'(bus.req_ready), 64'b1000);
    tick();
    bus.req_valid = '1;
    reset_n = 1'b0;
    settle();
    chk("mid_rst_mul_a", 64'(mul_a), 64'd0);
    chk("mid_rst_mul_b", 64'(mul_b), 64'd0);
    chk("mid_rst_mul_reset", 64'(mul_reset), 64'd1);
    chk("mid_rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    repeat (2) tick();
    bus.req_valid = '0;
    bus.rsp_ready = '1;
    reset_n = 1'b1;
    settle();
    chk("mid_mrst", 64'(mul_reset), 64'd1);
    for (int c = 0; c < 6; c++) begin
      tick();
      settle();
      chk("mid_no_stale_rsp", 64'(bus.rsp_valid), 64'd0);
      chk("mid_mul_reset_low", 64'(mul_reset), 64'd0);
    end
    chk("mid_idle", 64'(idle), 64'd1);

    // Randomized traffic against a due-time reference (rr_ptr=0, nothing busy)
    pend = '0;
    m_busy = '0;
    m_ptr = 0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      m_due[i] = 0;
      m_exp[i] = '0;
      pa[i] = '0;
      pb[i] = '0;
    end
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          pa[i] = $urandom;
          pb[i] = $urandom;
          set_op(i, pa[i], pb[i]);
        end
      end
      bus.req_valid = pend;
      bus.rsp_ready = NUM_REQ'($urandom);
      settle();
      exp_g = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        j = (m_ptr + k) % NUM_REQ;
        if (exp_g == '0 && pend[j] && !m_busy[j]) exp_g[j] = 1'b1;
      end
      for (int i = 0; i < int'(NUM_REQ); i++) exp_rv[i] = m_busy[i] && (c >= m_due[i]);
      chk("rand_grant", 64'(bus.req_ready), 64'(exp_g));
      chk("rand_rsp_valid", 64'(bus.rsp_valid), 64'(exp_rv));
      chk("rand_idle", 64'(idle), 64'(m_busy == '0));
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        if (exp_rv[i]) chk("rand_result", 64'(rslice(i)), 64'(m_exp[i]));
      end
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        if (exp_rv[i] && bus.rsp_ready[i]) m_busy[i] = 1'b0;
        if (exp_g[i]) begin
          m_busy[i] = 1'b1;
          m_due[i]  = c + int'(RSP_LAT);
          m_exp[i]  = pa[i] * pb[i];
          pend[i]   = 1'b0;
          m_ptr     = (i + 1) % NUM_REQ;
        end
      end
      tick();
    end
    wait_idle("rand_final_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
